// File: rtl/counter_seq_ctrl_pkg.sv
// ============================================================================
// | Module   : counter_seq_ctrl_pkg                                          |
// | Purpose  : Shared state encoding and default width for the counter        |
// |            sequencer and its datapath.                                    |
// | Revision : 1.0  initial release                                           |
// ============================================================================
`default_nettype none

package counter_seq_ctrl_pkg;

   localparam int c_width_default = 13;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   function automatic logic f_is_busy(input seq_state_t s);
      return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_HOLD);
   endfunction

endpackage

`default_nettype wire

// File: rtl/counter_seq_ctrl_tick_prescaler.sv
// ============================================================================
// | Module   : tick_prescaler                                                |
// | Purpose  : Mod-PRESCALE phase counter with freeze and clear; tick marks   |
// |            the last phase.                                                |
// | Revision : 1.0  initial release                                           |
// ============================================================================
`default_nettype none

module tick_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_run,
   input  logic i_clr,
   output logic o_tick
);

   localparam int c_pw = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_pw-1:0] c_last = c_pw'(PRESCALE - 1);

   logic [c_pw-1:0] r_phase;

   // Phase only advances while running, so a pause keeps it exactly where it was.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= '0;
      end else if (i_clr) begin
         r_phase <= '0;
      end else if (i_run) begin
         if (r_phase == c_last) begin
            r_phase <= '0;
         end else begin
            r_phase <= r_phase + c_pw'(1);
         end
      end
   end

   assign o_tick = (r_phase == c_last);

endmodule

`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
// ============================================================================
// | Module   : counter_seq_ctrl                                              |
// | Purpose  : Run-control sequencer that loads, steps and reloads an         |
// |            external up/down counter.                                      |
// | Revision : 1.0  initial release                                           |
// ============================================================================
`default_nettype none

module counter_seq_ctrl
   import counter_seq_ctrl_pkg::*;
#(
   parameter int WIDTH    = c_width_default,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_pause,
   input  logic             i_oneshot,
   input  logic             i_dir_up,
   input  logic [WIDTH-1:0] i_limit,
   input  logic [WIDTH-1:0] i_cnt_value,
   output logic             o_cnt_load,
   output logic [WIDTH-1:0] o_cnt_load_val,
   output logic             o_cnt_en,
   output logic             o_cnt_up,
   output logic             o_busy,
   output logic             o_done,
   output logic [2:0]       o_state
);

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_limit;
   logic             r_dir_up;
   logic             r_oneshot;

   logic             w_latch;
   logic             w_load;
   logic             w_en;
   logic             w_done;
   logic             w_ps_run;
   logic             w_ps_clr;
   logic             w_tick;
   logic             w_busy;
   logic [WIDTH-1:0] w_target;
   logic             w_at_target;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_tick_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_run  (w_ps_run),
      .i_clr  (w_ps_clr),
      .o_tick (w_tick)
   );

   // Equality only: a full-scale limit must not overflow any arithmetic.
   assign w_target    = r_dir_up ? r_limit : '0;
   assign w_at_target = (i_cnt_value == w_target);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_limit   <= '0;
         r_dir_up  <= 1'b0;
         r_oneshot <= 1'b0;
      end else if (w_latch) begin
         r_limit   <= i_limit;
         r_dir_up  <= i_dir_up;
         r_oneshot <= i_oneshot;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_load      = 1'b0;
      w_en        = 1'b0;
      w_done      = 1'b0;
      w_ps_run    = 1'b0;
      w_ps_clr    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start && !i_stop) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            w_load      = 1'b1;
            w_ps_clr    = 1'b1;
            w_state_nxt = i_stop ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            // stop outranks pause, pause outranks the tick.
            if (i_stop) begin
               w_state_nxt = ST_IDLE;
            end else if (i_pause) begin
               w_state_nxt = ST_HOLD;
            end else begin
               w_ps_run = 1'b1;
               if (w_tick) begin
                  if (w_at_target) begin
                     w_done = 1'b1;
                     if (r_oneshot) begin
                        w_state_nxt = ST_DONE;
                     end else begin
                        w_load = 1'b1;
                     end
                  end else begin
                     w_en = 1'b1;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (i_stop) begin
               w_state_nxt = ST_IDLE;
            end else if (!i_pause) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_busy         = f_is_busy(r_state);
   assign o_busy         = w_busy;
   assign o_cnt_load     = w_load;
   assign o_cnt_en       = w_en;
   assign o_done         = w_done;
   assign o_cnt_up       = w_busy & r_dir_up;
   assign o_cnt_load_val = (w_busy && !r_dir_up) ? r_limit : '0;
   assign o_state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
// ============================================================================
// | Module   : tb_counter_seq_ctrl                                           |
// | Purpose  : Scoreboard bench with a behavioural counter datapath.          |
// | Revision : 1.0  initial release                                           |
// ============================================================================
`default_nettype none

module tb_counter_seq_ctrl;
   import counter_seq_ctrl_pkg::*;

   localparam int W = 13;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_start, i_stop, i_pause, i_oneshot, i_dir_up;
   logic [W-1:0] i_limit;
   logic [W-1:0] m_cnt;
   logic         o_cnt_load, o_cnt_en, o_cnt_up, o_busy, o_done;
   logic [W-1:0] o_cnt_load_val;
   logic [2:0]   o_state;

   counter_seq_ctrl #(.WIDTH(W), .PRESCALE(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_start        (i_start),
      .i_stop         (i_stop),
      .i_pause        (i_pause),
      .i_oneshot      (i_oneshot),
      .i_dir_up       (i_dir_up),
      .i_limit        (i_limit),
      .i_cnt_value    (m_cnt),
      .o_cnt_load     (o_cnt_load),
      .o_cnt_load_val (o_cnt_load_val),
      .o_cnt_en       (o_cnt_en),
      .o_cnt_up       (o_cnt_up),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_state        (o_state)
   );

   always #5 clk = ~clk;

   // Counter datapath model: load beats enable, direction from cnt_up.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          m_cnt <= '0;
      else if (o_cnt_load) m_cnt <= o_cnt_load_val;
      else if (o_cnt_en)   m_cnt <= o_cnt_up ? m_cnt + 1'b1 : m_cnt - 1'b1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit load;
      bit done;
      int lv;
      int cnt;
   } ev_t;

   ev_t q[$];
   ev_t e;
   int  n_checks = 0;
   int  n_err    = 0;
   int  en_seen  = 0;
   int  s;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic ev_t mk(input int c, input bit ld, input bit dn, input int lv, input int cnt);
      ev_t r;
      r.cyc = c; r.load = ld; r.done = dn; r.lv = lv; r.cnt = cnt;
      return r;
   endfunction

   // Monitor: pops one expectation per load/done presentation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_cnt_en) en_seen++;
         if (o_cnt_load || o_done) begin
            if (q.size() == 0) begin
               chk("unexpected_event_cycle", cyc, -1);
            end else begin
               e = q.pop_front();
               chk("ev_cycle", cyc, e.cyc);
               chk("ev_load", o_cnt_load, e.load);
               chk("ev_done", o_done, e.done);
               if (e.load) chk("ev_load_val", o_cnt_load_val, e.lv);
               if (e.done) chk("ev_cnt_at_done", m_cnt, e.cnt);
            end
         end
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic do_start(input int lim, input bit up, input bit os);
      i_limit   = W'(lim);
      i_dir_up  = up;
      i_oneshot = os;
      i_start   = 1'b1;
      @(negedge clk);
      i_start   = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; i_start = 0; i_stop = 0; i_pause = 0;
      i_oneshot = 0; i_dir_up = 0; i_limit = '0;
      repeat (2) @(negedge clk);
      chk("rst_state", o_state, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_load", o_cnt_load, 0);
      chk("rst_en", o_cnt_en, 0);
      chk("rst_done", o_done, 0);
      chk("rst_up", o_cnt_up, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_rst", o_state, ST_IDLE);

      // Oneshot up to 5, with an ignored start while running.
      en_seen = 0;
      s = cyc + 1;
      q.push_back(mk(s, 1, 0, 0, 0));
      q.push_back(mk(s + 24, 0, 1, 0, 5));
      do_start(5, 1'b1, 1'b1);
      chk("t1_clear_state", o_state, ST_CLEAR);
      chk("t1_clear_busy", o_busy, 1);
      wait_until(s + 8);
      i_limit = 13'd2; i_dir_up = 1'b0; i_oneshot = 1'b0; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk("t4_start_in_run_state", o_state, ST_RUN);
      chk("t4_start_in_run_dir", o_cnt_up, 1);
      wait_until(s + 25);
      chk("t1_done_state", o_state, ST_DONE);
      chk("t1_done_busy", o_busy, 0);
      wait_until(s + 26);
      chk("t1_idle", o_state, ST_IDLE);
      chk("t1_cnt_hold", m_cnt, 5);
      chk("t1_en_count", en_seen, 5);

      // Same run with a 10-cycle stall, plus an ignored start in HOLD.
      en_seen = 0;
      s = cyc + 1;
      q.push_back(mk(s, 1, 0, 0, 0));
      q.push_back(mk(s + 34, 0, 1, 0, 5));
      do_start(5, 1'b1, 1'b1);
      wait_until(s + 6);
      i_pause = 1'b1;
      wait_until(s + 10);
      chk("t3_hold_state", o_state, ST_HOLD);
      chk("t3_hold_cnt", m_cnt, 1);
      i_limit = 13'd7; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk("t4_start_in_hold", o_state, ST_HOLD);
      wait_until(s + 15);
      chk("t3_hold_cnt_frozen", m_cnt, 1);
      i_pause = 1'b0;
      wait_until(s + 16);
      chk("t3_resume", o_state, ST_RUN);
      wait_until(s + 36);
      chk("t3_idle", o_state, ST_IDLE);
      chk("t3_en_count", en_seen, 5);
      chk("t3_cnt_final", m_cnt, 5);

      // Free-running down from 3, then stop.
      en_seen = 0;
      s = cyc + 1;
      q.push_back(mk(s, 1, 0, 3, 0));
      for (int k = 1; k <= 3; k++) q.push_back(mk(s + 16 * k, 1, 1, 3, 0));
      do_start(3, 1'b0, 1'b0);
      chk("t2_load_dir", o_cnt_up, 0);
      wait_until(s + 50);
      i_stop = 1'b1;
      @(negedge clk);
      i_stop = 1'b0;
      chk("t2_stop_idle", o_state, ST_IDLE);
      chk("t2_stop_busy", o_busy, 0);
      chk("t2_en_count", en_seen, 9);
      repeat (20) @(negedge clk);
      chk("t2_no_en_after_stop", en_seen, 9);

      // start and stop together in IDLE.
      i_start = 1'b1; i_stop = 1'b1;
      @(negedge clk);
      i_start = 1'b0; i_stop = 1'b0;
      chk("t4_start_stop_state", o_state, ST_IDLE);
      @(negedge clk);
      chk("t4_start_stop_busy", o_busy, 0);

      // limit = 0, oneshot up.
      en_seen = 0;
      s = cyc + 1;
      q.push_back(mk(s, 1, 0, 0, 0));
      q.push_back(mk(s + 4, 0, 1, 0, 0));
      do_start(0, 1'b1, 1'b1);
      wait_until(s + 6);
      chk("t5_zero_idle", o_state, ST_IDLE);
      chk("t5_zero_en", en_seen, 0);

      // Full-scale limit, free-running up: one wrap after 8192 ticks.
      en_seen = 0;
      s = cyc + 1;
      q.push_back(mk(s, 1, 0, 0, 0));
      q.push_back(mk(s + 4 * 8192, 1, 1, 0, 8191));
      do_start(8191, 1'b1, 1'b0);
      wait_until(s + 4 * 8192 + 2);
      i_stop = 1'b1;
      @(negedge clk);
      i_stop = 1'b0;
      chk("t5_max_idle", o_state, ST_IDLE);
      chk("t5_max_en", en_seen, 8191);
      chk("t5_max_cnt", m_cnt, 0);

      // Asynchronous reset between edges mid-run.
      s = cyc + 1;
      q.push_back(mk(s, 1, 0, 0, 0));
      do_start(5, 1'b1, 1'b1);
      wait_until(s + 10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_state", o_state, 0);
      chk("t6_async_busy", o_busy, 0);
      chk("t6_async_up", o_cnt_up, 0);
      chk("t6_async_en", o_cnt_en, 0);
      chk("t6_async_load", o_cnt_load, 0);
      chk("t6_async_done", o_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_post_idle", o_state, ST_IDLE);
      chk("t6_post_busy", o_busy, 0);

      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
